// File: rtl/reggen_apb_pkg.sv
// Shared definitions for the reggen APB requester and the generated register files.
//   - apb_state_e : transfer FSM states (IDLE / SETUP / ACCESS / RESP)
//   - PPROT_*_BIT : bit positions within pprot
//   - REGGEN_DEFAULT_* : default widths and timeout shared with generated code
package reggen_apb_pkg;

  localparam int REGGEN_DEFAULT_ADDR_WIDTH = 16;
  localparam int REGGEN_DEFAULT_DATA_WIDTH = 32;
  localparam int REGGEN_DEFAULT_TIMEOUT    = 256;

  localparam int PPROT_PRIVILEGED_BIT  = 0;
  localparam int PPROT_NONSECURE_BIT   = 1;
  localparam int PPROT_INSTRUCTION_BIT = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/reggen_apb_master_if.sv
// Bundle of the command/response handshake and the APB4 bus seen by the requester.
//   modport master : view of reggen_apb_master (takes commands, drives APB)
//   modport slave  : view of the command source plus APB completer
interface reggen_apb_master_if
  import reggen_apb_pkg::*;
#(
  parameter int REGGEN_ADDR_WIDTH = REGGEN_DEFAULT_ADDR_WIDTH,
  parameter int REGGEN_DATA_WIDTH = REGGEN_DEFAULT_DATA_WIDTH
);
  localparam int REGGEN_STRB_WIDTH = REGGEN_DATA_WIDTH / 8;

  // command channel
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic                         cmd_write;
  logic [REGGEN_ADDR_WIDTH-1:0] cmd_addr;
  logic [REGGEN_DATA_WIDTH-1:0] cmd_wdata;
  logic [REGGEN_STRB_WIDTH-1:0] cmd_strb;
  logic [2:0]                   cmd_prot;
  // response channel
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [REGGEN_DATA_WIDTH-1:0] rsp_rdata;
  logic                         rsp_slverr;
  logic                         rsp_timeout;
  // APB4
  logic                         psel;
  logic                         penable;
  logic                         pwrite;
  logic [REGGEN_ADDR_WIDTH-1:0] paddr;
  logic [REGGEN_DATA_WIDTH-1:0] pwdata;
  logic [REGGEN_STRB_WIDTH-1:0] pstrb;
  logic [2:0]                   pprot;
  logic                         pready;
  logic                         pslverr;
  logic [REGGEN_DATA_WIDTH-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, pslverr, prdata
  );

endinterface

// File: rtl/reggen_apb_timeout.sv
// ACCESS-phase wait counter for the APB requester.
//   pclk, preset_n : clock, asynchronous active-low reset
//   clr            : restart the count (new transfer entering SETUP)
//   inc            : one more ACCESS cycle without pready
//   expired        : count has reached REGGEN_TIMEOUT
// With REGGEN_TIMEOUT = 0 the counter is removed and expired is tied low.
module reggen_apb_timeout #(
  parameter int REGGEN_TIMEOUT = 256
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = (REGGEN_TIMEOUT > 0) ? $clog2(REGGEN_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(REGGEN_TIMEOUT);

  if (REGGEN_TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = &{1'b0, pclk, preset_n, clr, inc};
    assign expired = 1'b0;
  end else begin : g_on
    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
        cnt_q <= '0;
      end else if (clr) begin
        cnt_q <= '0;
      end else if (inc && (cnt_q != LIMIT)) begin
        // Saturate at the limit; the FSM leaves ACCESS once it is reached.
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign expired = (cnt_q == LIMIT);
  end

endmodule

// File: rtl/reggen_apb_master.sv
// APB4 requester: turns one valid/ready command into one APB transfer and
// returns a single response; aborts a transfer whose completer never answers.
//   pclk, preset_n : APB clock, asynchronous active-low reset
//   bus (master)   : cmd_* command in, rsp_* response out, p* APB4 bus
// All outputs are registered except cmd_ready (state == IDLE).
module reggen_apb_master
  import reggen_apb_pkg::*;
#(
  parameter int REGGEN_ADDR_WIDTH = REGGEN_DEFAULT_ADDR_WIDTH,
  parameter int REGGEN_DATA_WIDTH = REGGEN_DEFAULT_DATA_WIDTH,
  parameter int REGGEN_TIMEOUT    = REGGEN_DEFAULT_TIMEOUT
) (
  input  logic                pclk,
  input  logic                preset_n,
  reggen_apb_master_if.master bus
);

  localparam int REGGEN_STRB_WIDTH = REGGEN_DATA_WIDTH / 8;

  apb_state_e state_q, state_d;
  logic       accept;
  logic       complete;
  logic       timed_out;
  logic       waiting;
  logic       expired;

  assign accept    = (state_q == IDLE) && bus.cmd_valid;
  assign waiting   = (state_q == ACCESS) && !bus.pready;
  assign complete  = (state_q == ACCESS) && bus.pready;
  // pready on the limit cycle wins, so expiry only matters while still waiting.
  assign timed_out = waiting && expired;

  assign bus.cmd_ready = (state_q == IDLE);

  reggen_apb_timeout #(
    .REGGEN_TIMEOUT(REGGEN_TIMEOUT)
  ) u_timeout (
    .pclk    (pclk),
    .preset_n(preset_n),
    .clr     (accept),
    .inc     (waiting),
    .expired (expired)
  );

  // NOTE: state_d gets a default before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid)          state_d = SETUP;
      SETUP:                               state_d = ACCESS;
      ACCESS:  if (complete || timed_out)  state_d = RESP;
      RESP:    if (bus.rsp_ready)          state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Bus and response registers; control strobes are the registered decode of
  // the next state so they line up exactly with the FSM.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.pwrite      <= 1'b0;
      bus.paddr       <= {REGGEN_ADDR_WIDTH{1'b0}};
      bus.pwdata      <= {REGGEN_DATA_WIDTH{1'b0}};
      bus.pstrb       <= {REGGEN_STRB_WIDTH{1'b0}};
      bus.pprot       <= 3'b000;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= {REGGEN_DATA_WIDTH{1'b0}};
      bus.rsp_slverr  <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.psel      <= (state_d == SETUP) || (state_d == ACCESS);
      bus.penable   <= (state_d == ACCESS);
      bus.rsp_valid <= (state_d == RESP);

      if (accept) begin
        bus.paddr  <= bus.cmd_addr;
        bus.pwrite <= bus.cmd_write;
        bus.pprot  <= bus.cmd_prot;
        // Reads carry no write data or strobes on the bus.
        bus.pwdata <= bus.cmd_write ? bus.cmd_wdata : {REGGEN_DATA_WIDTH{1'b0}};
        bus.pstrb  <= bus.cmd_write ? bus.cmd_strb  : {REGGEN_STRB_WIDTH{1'b0}};
      end

      if (complete) begin
        bus.rsp_rdata   <= bus.pwrite ? {REGGEN_DATA_WIDTH{1'b0}} : bus.prdata;
        bus.rsp_slverr  <= bus.pslverr;
        bus.rsp_timeout <= 1'b0;
      end else if (timed_out) begin
        bus.rsp_rdata   <= {REGGEN_DATA_WIDTH{1'b0}};
        bus.rsp_slverr  <= 1'b1;
        bus.rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
